// File: rtl/stegano_if.sv
// Cover-byte input and ciphertext-block output bundle for the stego extractor.
// The slave side is the extractor. The master side is the cover source plus the AES decryptor.
interface stegano_if #(
    parameter int BLOCK_W = 128
);
    logic               in_valid;
    logic               in_sof;
    logic [7:0]         stego_in;
    logic               in_ready;
    logic [BLOCK_W-1:0] blk_out;
    logic               blk_valid;
    logic               blk_ready;
    logic               busy;
    logic               err_sync;
    logic [15:0]        blk_cnt;

    modport slave (
        input  in_valid, in_sof, stego_in, blk_ready,
        output in_ready, blk_out, blk_valid, busy, err_sync, blk_cnt
    );

    modport master (
        output in_valid, in_sof, stego_in, blk_ready,
        input  in_ready, blk_out, blk_valid, busy, err_sync, blk_cnt
    );
endinterface

// File: rtl/stegano_extract.sv
// Recovers BLOCK_W-bit ciphertext blocks from the BPB LSBs of each stego cover byte.
// Each completed block is handed to the decryptor over a valid/ready handshake.
module stegano_extract #(
    parameter int BLOCK_W = 128,
    parameter int BPB     = 1
) (
    input  logic     clk,
    input  logic     rst,
    stegano_if.slave bus
);
    localparam int NB    = BLOCK_W / BPB;
    localparam int CNT_W = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BLOCK_W-1:0] r_blk;
    logic               r_blk_valid;
    logic               r_busy;
    logic               r_err_sync;
    logic [15:0]        r_blk_cnt;

    wire                w_accept = bus.in_valid && (r_state != S_HOLD);
    wire [BLOCK_W-1:0]  w_shifted = {r_blk[BLOCK_W-BPB-1:0], bus.stego_in[BPB-1:0]};
    wire                w_unused_hi = ^bus.stego_in[7:BPB];

    assign bus.in_ready  = (r_state != S_HOLD);
    assign bus.blk_out   = r_blk;
    assign bus.blk_valid = r_blk_valid;
    assign bus.busy      = r_busy;
    assign bus.err_sync  = r_err_sync;
    assign bus.blk_cnt   = r_blk_cnt;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_blk       <= '0;
            r_blk_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err_sync  <= 1'b0;
            r_blk_cnt   <= '0;
        end else begin
            r_err_sync <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && bus.in_sof) begin
                        r_blk   <= w_shifted;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_accept) begin
                        r_blk <= w_shifted;
                        // A new frame start mid-block abandons the partial block and restarts it.
                        if (bus.in_sof && (r_cnt != '0)) begin
                            r_err_sync <= 1'b1;
                            r_cnt      <= CNT_W'(1);
                        end else if (r_cnt == LAST_CNT) begin
                            r_cnt       <= '0;
                            r_blk_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.blk_ready) begin
                        r_blk_valid <= 1'b0;
                        r_blk_cnt   <= r_blk_cnt + 16'd1;
                        r_state     <= S_COLLECT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
